// File: rtl/musb_multicycle_div_pkg.sv
// ============================================================================
//  musb_multicycle_div_pkg
//  Shared state encoding and constants for the iterative EX-stage divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package musb_multicycle_div_pkg;

    localparam int MUSB_DIV_ITER = 32;

    localparam logic [31:0] MUSB_DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MUSB_DIV_IDLE = 2'd0,
        MUSB_DIV_BUSY = 2'd1,
        MUSB_DIV_DONE = 2'd2
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/musb_multicycle_div_if.sv
// ============================================================================
//  musb_multicycle_div_if
//  EX-stage operand/control bundle and result/stall bundle of the divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface musb_multicycle_div_if #(
    parameter int DATA_W = 32
);
    logic              op_divs;
    logic              op_divu;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              ex_stall_unit;
    logic              ex_flush;
    logic              ex_request_stall;
    logic              div_busy;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              result_valid;

    modport master (
        output op_divs, op_divu, op_a, op_b, ex_stall_unit, ex_flush,
        input  ex_request_stall, div_busy, quotient, remainder, result_valid
    );

    modport slave (
        input  op_divs, op_divu, op_a, op_b, ex_stall_unit, ex_flush,
        output ex_request_stall, div_busy, quotient, remainder, result_valid
    );
endinterface

`default_nettype wire

// File: rtl/musb_multicycle_div_signfix.sv
// ============================================================================
//  musb_multicycle_div_signfix
//  Conditional two's-complement of a value pair (operand abs / result fix).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module musb_multicycle_div_signfix #(
    parameter int DATA_W = 32
) (
    input  wire logic [DATA_W-1:0] a_i,
    input  wire logic [DATA_W-1:0] b_i,
    input  wire logic              neg_a_i,
    input  wire logic              neg_b_i,
    output logic      [DATA_W-1:0] a_o,
    output logic      [DATA_W-1:0] b_o
);
    assign a_o = neg_a_i ? -a_i : a_i;
    assign b_o = neg_b_i ? -b_i : b_i;
endmodule

`default_nettype wire

// File: rtl/musb_multicycle_div.sv
// ============================================================================
//  musb_multicycle_div
//  Radix-2 restoring DIV/DIVU unit with EX stall request; optional early-out
//  selected by MUSB_DIV_EARLY_OUT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module musb_multicycle_div
    import musb_multicycle_div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  wire logic            clk,
    input  wire logic            rst,
    musb_multicycle_div_if.slave bus
);
    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] rem_q;
    logic              qneg_q;
    logic              rneg_q;
    logic [DATA_W-1:0] quotient_q;
    logic [DATA_W-1:0] remainder_q;
    logic              valid_q;

    logic              is_signed;
    logic              start;
    logic [DATA_W:0]   shift_d;
    logic [DATA_W:0]   diff_d;
    logic              ge_d;
    logic [DATA_W-1:0] rem_step_d;
    logic [DATA_W-1:0] quo_step_d;
    logic [DATA_W-1:0] res_q_d;
    logic [DATA_W-1:0] res_r_d;
    logic              last_step;
    logic [DATA_W-1:0] sf_a, sf_b;
    logic              sf_na, sf_nb;
    logic [DATA_W-1:0] fix_a_d, fix_b_d;

    // DIV wins when both opcode strobes are (illegally) set.
    assign is_signed = bus.op_divs;
    assign start     = (state_q == MUSB_DIV_IDLE) & (bus.op_divs | bus.op_divu)
                     & ~bus.ex_stall_unit & ~bus.ex_flush;

    assign shift_d    = {rem_q, dvd_q[DATA_W-1]};
    assign diff_d     = shift_d - {1'b0, dvs_q};
    assign ge_d       = ~diff_d[DATA_W];
    assign rem_step_d = ge_d ? diff_d[DATA_W-1:0] : shift_d[DATA_W-1:0];
    assign quo_step_d = {dvd_q[DATA_W-2:0], ge_d};

`ifdef MUSB_DIV_EARLY_OUT_EN
    logic early_q;

    assign res_q_d   = early_q ? ((dvs_q == '0) ? MUSB_DIV_BY_ZERO_Q : '0) : quo_step_d;
    assign res_r_d   = early_q ? dvd_q : rem_step_d;
    assign last_step = early_q | (cnt_q == '0);
`else
    assign res_q_d   = quo_step_d;
    assign res_r_d   = rem_step_d;
    assign last_step = (cnt_q == '0);
`endif

    // One sign-fix block: operand magnitudes in IDLE, final result otherwise.
    always_comb begin
        sf_a  = res_q_d;
        sf_b  = res_r_d;
        sf_na = qneg_q;
        sf_nb = rneg_q;
        if (state_q == MUSB_DIV_IDLE) begin
            sf_a  = bus.op_a;
            sf_b  = bus.op_b;
            sf_na = is_signed & bus.op_a[DATA_W-1];
            sf_nb = is_signed & bus.op_b[DATA_W-1];
        end
    end

    musb_multicycle_div_signfix #(.DATA_W(DATA_W)) u_signfix (
        .a_i     (sf_a),
        .b_i     (sf_b),
        .neg_a_i (sf_na),
        .neg_b_i (sf_nb),
        .a_o     (fix_a_d),
        .b_o     (fix_b_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MUSB_DIV_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
`ifdef MUSB_DIV_EARLY_OUT_EN
            early_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                MUSB_DIV_IDLE: begin
                    if (start) begin
                        dvd_q   <= fix_a_d;
                        dvs_q   <= fix_b_d;
                        rem_q   <= '0;
                        // A zero divisor keeps the all-ones quotient unsigned.
                        qneg_q  <= is_signed & (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1])
                                 & (bus.op_b != '0);
                        rneg_q  <= is_signed & bus.op_a[DATA_W-1];
                        cnt_q   <= CNT_W'(DATA_W - 1);
`ifdef MUSB_DIV_EARLY_OUT_EN
                        early_q <= (bus.op_b == '0) | (fix_a_d < fix_b_d);
`endif
                        state_q <= MUSB_DIV_BUSY;
                    end
                end
                MUSB_DIV_BUSY: begin
                    if (bus.ex_flush) begin
                        state_q <= MUSB_DIV_IDLE;
                    end else if (!bus.ex_stall_unit) begin
                        if (last_step) begin
                            quotient_q  <= fix_a_d;
                            remainder_q <= fix_b_d;
                            valid_q     <= 1'b1;
                            state_q     <= MUSB_DIV_DONE;
                        end else begin
                            dvd_q <= quo_step_d;
                            rem_q <= rem_step_d;
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                MUSB_DIV_DONE: begin
                    if (bus.ex_flush || !bus.ex_stall_unit) begin
                        valid_q <= 1'b0;
                        state_q <= MUSB_DIV_IDLE;
                    end
                end
                default: state_q <= MUSB_DIV_IDLE;
            endcase
        end
    end

    assign bus.ex_request_stall = (state_q == MUSB_DIV_IDLE) ? start
                                : (state_q == MUSB_DIV_BUSY) ? ~bus.ex_flush
                                : 1'b0;
    assign bus.div_busy     = (state_q != MUSB_DIV_IDLE);
    assign bus.result_valid = valid_q & ~bus.ex_flush;
    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_musb_multicycle_div.sv
// ============================================================================
//  tb_musb_multicycle_div
//  Directed + randomized checks of the divider against an arithmetic model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_musb_multicycle_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    musb_multicycle_div_if #(.DATA_W(32)) bus();

    musb_multicycle_div #(.DATA_W(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Architectural result of DIV/DIVU, straight from the arithmetic rules.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;
    mph_t        m_ph = M_IDLE;
    int          m_left = 0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;

    initial begin : compare
        logic st, s;
        logic [31:0] aa, ab;
        forever begin
            @(negedge clk);
            st = (bus.op_divs | bus.op_divu) & ~bus.ex_stall_unit & ~bus.ex_flush;
            if (rst) begin
                chk("rst stall", bus.ex_request_stall, 0);
                chk("rst busy", bus.div_busy, 0);
                chk("rst valid", bus.result_valid, 0);
                chk("rst quotient", bus.quotient, 0);
                chk("rst remainder", bus.remainder, 0);
                m_ph = M_IDLE;
            end else begin
                case (m_ph)
                    M_IDLE: begin
                        chk("idle stall", bus.ex_request_stall, st);
                        chk("idle busy", bus.div_busy, 0);
                        chk("idle valid", bus.result_valid, 0);
                        if (st) begin
                            s = bus.op_divs;
                            ref_div(s, bus.op_a, bus.op_b, m_q, m_r);
                            aa = (s && bus.op_a[31]) ? -bus.op_a : bus.op_a;
                            ab = (s && bus.op_b[31]) ? -bus.op_b : bus.op_b;
                            m_left = 32;
`ifdef MUSB_DIV_EARLY_OUT_EN
                            if (bus.op_b == 32'd0 || aa < ab) m_left = 1;
`endif
                            m_ph = M_BUSY;
                        end
                    end
                    M_BUSY: begin
                        chk("busy stall", bus.ex_request_stall, !bus.ex_flush);
                        chk("busy busy", bus.div_busy, 1);
                        chk("busy valid", bus.result_valid, 0);
                        if (bus.ex_flush) m_ph = M_IDLE;
                        else if (!bus.ex_stall_unit) begin
                            m_left--;
                            if (m_left == 0) m_ph = M_DONE;
                        end
                    end
                    default: begin
                        chk("done stall", bus.ex_request_stall, 0);
                        chk("done busy", bus.div_busy, 1);
                        chk("done valid", bus.result_valid, !bus.ex_flush);
                        if (!bus.ex_flush) begin
                            chk("done quotient", bus.quotient, m_q);
                            chk("done remainder", bus.remainder, m_r);
                        end
                        if (bus.ex_flush || !bus.ex_stall_unit) m_ph = M_IDLE;
                    end
                endcase
            end
        end
    end

    task automatic clear_inputs();
        bus.op_divs = 0; bus.op_divu = 0; bus.op_a = '0; bus.op_b = '0;
        bus.ex_stall_unit = 0; bus.ex_flush = 0;
    endtask

    // Holds one instruction in EX until it completes, is flushed, or times out.
    task automatic run_op(input bit s, input bit u, input logic [31:0] a, input logic [31:0] b,
                          input int frz_at, input int frz_len, input int fl_at,
                          output int nst, output int nval,
                          output logic [31:0] q, output logic [31:0] r);
        bit fin;
        nst = 0; nval = 0; q = '0; r = '0; fin = 0;
        bus.op_divs = s; bus.op_divu = u; bus.op_a = a; bus.op_b = b;
        bus.ex_stall_unit = (frz_len > 0 && frz_at == 0);
        bus.ex_flush = (fl_at == 0);
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            if (bus.ex_request_stall) nst++;
            if (bus.result_valid) begin
                nval++;
                q = bus.quotient;
                r = bus.remainder;
            end
            fin = bus.ex_flush || (bus.result_valid && !bus.ex_stall_unit);
            @(posedge clk); #1;
            if (fin) clear_inputs();
            else begin
                bus.ex_stall_unit = (c + 1 >= frz_at && c + 1 < frz_at + frz_len);
                bus.ex_flush = (c + 1 == fl_at);
            end
        end
        if (!fin) begin
            n_vec++; n_err++;
            $display("FAIL run_op timeout: got no completion expected completion within 300 cycles");
            clear_inputs();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    int nst, nval;
    logic [31:0] q, r;
    int exp_5_0_stall;

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

`ifdef MUSB_DIV_EARLY_OUT_EN
        exp_5_0_stall = 2;
`else
        exp_5_0_stall = 33;
`endif

        run_op(0, 1, 32'd100, 32'd7, 0, 0, -1, nst, nval, q, r);
        chk("divu 100/7 stall", nst, 33);
        chk("divu 100/7 q", q, 14);
        chk("divu 100/7 r", r, 2);
        chk("divu 100/7 valid cycles", nval, 1);

        run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, -1, nst, nval, q, r);
        chk("div -7/2 q", q, 32'hFFFF_FFFD);
        chk("div -7/2 r", r, 32'hFFFF_FFFF);

        run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1, nst, nval, q, r);
        chk("div ovf q", q, 32'h8000_0000);
        chk("div ovf r", r, 0);

        run_op(0, 1, 32'd5, 32'd0, 0, 0, -1, nst, nval, q, r);
        chk("divu 5/0 q", q, 32'hFFFF_FFFF);
        chk("divu 5/0 r", r, 5);
        chk("divu 5/0 stall", nst, exp_5_0_stall);

        run_op(0, 1, 32'd1000, 32'd3, 10, 4, -1, nst, nval, q, r);
        chk("divu 1000/3 frz stall", nst, 37);
        chk("divu 1000/3 frz q", q, 333);
        chk("divu 1000/3 frz r", r, 1);

        run_op(0, 1, 32'd1000, 32'd3, 33, 3, -1, nst, nval, q, r);
        chk("done hold valid cycles", nval, 4);
        chk("done hold q", q, 333);
        chk("done hold r", r, 1);

        run_op(0, 1, 32'd1000, 32'd3, 0, 0, 10, nst, nval, q, r);
        chk("flush valid cycles", nval, 0);
        chk("flush stall", nst, 10);

        run_op(0, 1, 32'd9, 32'd3, 0, 0, -1, nst, nval, q, r);
        chk("after flush stall", nst, 33);
        chk("after flush q", q, 3);
        chk("after flush r", r, 0);

        run_op(0, 1, 32'd20, 32'd6, 0, 0, -1, nst, nval, q, r);
        chk("b2b 20/6 q", q, 3);
        chk("b2b 20/6 r", r, 2);
        run_op(0, 1, 32'd21, 32'd4, 0, 0, -1, nst, nval, q, r);
        chk("b2b 21/4 q", q, 5);
        chk("b2b 21/4 r", r, 1);

        // Asynchronous reset in the middle of an operation.
        bus.op_divu = 1; bus.op_a = 32'd100; bus.op_b = 32'd7;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("async rst busy", bus.div_busy, 0);
        chk("async rst valid", bus.result_valid, 0);
        chk("async rst q", bus.quotient, 0);
        chk("async rst r", bus.remainder, 0);
        chk("async rst stall", bus.ex_request_stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 120; i++) begin
            bit s, u;
            int fa, fl, fn;
            if ($urandom_range(0, 3) == 0) begin
                bus.ex_stall_unit = ($urandom_range(0, 1) == 1);
                @(posedge clk); #1;
                bus.ex_stall_unit = 0;
            end
            s = ($urandom_range(0, 1) == 1);
            u = !s || ($urandom_range(0, 7) == 0);
            fa = $urandom_range(0, 40);
            fn = $urandom_range(0, 4);
            fl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 35) : -1;
            run_op(s, u, pick(), pick(), fa, fn, fl, nst, nval, q, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
